// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and helpers for the data-memory port arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } owner_t;

    localparam int DEF_MAX_BURST = 4;

    // burst_cnt must hold 0..max_burst inclusive
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational winner selection for the port arbiter
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int CPU_PRIORITY = 1,
    parameter int CNT_W        = burst_cnt_w(MAX_BURST)
) (
    input  state_t           state,
    input  logic [CNT_W-1:0] burst_cnt,
    input  owner_t           last_owner,
    input  logic             a_req,
    input  logic             b_req,
    output owner_t           winner,
    output logic             valid
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    // The current owner keeps the port until its burst is used up while the other side waits
    always_comb begin
        winner = PORT_A;
        valid  = 1'b0;
        case (state)
            OWN_A: begin
                if (a_req && (!b_req || (burst_cnt < MAX_CNT))) begin
                    winner = PORT_A;
                    valid  = 1'b1;
                end else if (b_req) begin
                    winner = PORT_B;
                    valid  = 1'b1;
                end
            end
            OWN_B: begin
                if (b_req && (!a_req || (burst_cnt < MAX_CNT))) begin
                    winner = PORT_B;
                    valid  = 1'b1;
                end else if (a_req) begin
                    winner = PORT_A;
                    valid  = 1'b1;
                end
            end
            default: begin
                if (a_req && b_req) begin
                    valid = 1'b1;
                    if (CPU_PRIORITY != 0) begin
                        winner = PORT_A;
                    end else begin
                        winner = (last_owner == PORT_A) ? PORT_B : PORT_A;
                    end
                end else if (a_req) begin
                    winner = PORT_A;
                    valid  = 1'b1;
                end else if (b_req) begin
                    winner = PORT_B;
                    valid  = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one single-port data memory between CPU and DMA ports
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int CPU_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int               CNT_W   = burst_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_t           state;
    logic [CNT_W-1:0] burst_cnt;
    owner_t           last_owner;

    owner_t pick_winner;
    logic   pick_valid;
    logic   grant_valid;
    logic   sel_a;
    logic   sel_b;
    state_t win_state;

    dmem_arb_pick #(
        .MAX_BURST    (MAX_BURST),
        .CPU_PRIORITY (CPU_PRIORITY),
        .CNT_W        (CNT_W)
    ) u_pick (
        .state      (state),
        .burst_cnt  (burst_cnt),
        .last_owner (last_owner),
        .a_req      (a_req),
        .b_req      (b_req),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // A request seen while in reset is dropped rather than granted
    assign grant_valid = pick_valid & rst_n;
    assign sel_a       = grant_valid & (pick_winner == PORT_A);
    assign sel_b       = grant_valid & (pick_winner == PORT_B);
    assign a_gnt       = sel_a;
    assign b_gnt       = sel_b;
    assign win_state   = (pick_winner == PORT_A) ? OWN_A : OWN_B;

    // Route the winning port onto the memory pins; idle pins sit at zero
    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (sel_a) begin
            mem_address    = a_addr;
            mem_write_data = a_wdata;
            mem_write      = a_we;
            mem_read       = ~a_we;
        end else if (sel_b) begin
            mem_address    = b_addr;
            mem_write_data = b_wdata;
            mem_write      = b_we;
            mem_read       = ~b_we;
        end
    end

    // Ownership FSM: track owner, consecutive-grant count and the last port served
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= PORT_B;
        end else if (grant_valid) begin
            state      <= win_state;
            last_owner <= pick_winner;
            if (state == win_state) begin
                burst_cnt <= (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + CNT_W'(1);
            end else begin
                burst_cnt <= CNT_W'(1);
            end
        end else begin
            state     <= IDLE;
            burst_cnt <= '0;
        end
    end

    // Capture read data one cycle after a read grant; rdata holds until the next read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= sel_a & ~a_we;
            b_rvalid <= sel_b & ~b_we;
            if (sel_a && !a_we) begin
                a_rdata <= mem_read_data;
            end
            if (sel_b && !b_we) begin
                b_rdata <= mem_read_data;
            end
        end
    end

endmodule
